// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix coprocessor command sequencer.
//   - Command opcode encodings and the datapath (ALU) select encodings
//   - Sequencer FSM state encoding
//   - Default word/address widths and the wait-counter width
//   - Helpers: opcode legality and opcode -> ALU select mapping
package matrix_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 256;
  localparam int WAIT_W     = 3;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_TRANSPOSE = 3'b011;

  localparam logic [1:0] ALU_SUM       = 2'b00;
  localparam logic [1:0] ALU_SUB       = 2'b01;
  localparam logic [1:0] ALU_TRANSPOSE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_A  = 3'd1,
    ST_RD_B  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_TRANSPOSE);
  endfunction

  function automatic logic [1:0] op_to_alu_sel(input logic [2:0] op);
    logic [1:0] sel;
    case (op)
      OP_SUB:       sel = ALU_SUB;
      OP_TRANSPOSE: sel = ALU_TRANSPOSE;
      default:      sel = ALU_SUM;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/matrix_wait_counter.sv
// Loadable down-counter used by the sequencer to time RAM read and ALU waits.
//   mclk     : clock, posedge
//   rst      : synchronous, active-low reset (counter clears to zero)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load; the zero flag rises load_val cycles later
//   zero     : counter is at zero
module matrix_wait_counter
  import matrix_pkg::*;
(
  input  logic              mclk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  output logic              zero
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Command sequencer for the matrix coprocessor. Accepts one instruction per
// valid/ready handshake, reads operand A (and B for ADD/SUB) from the
// single-port RAM, presents registered operands to the add/sub/transpose
// datapath, captures the result and writes it back to RAM.
//   mclk, rst                 : clock (posedge) and synchronous active-low reset
//   cmd_valid/cmd_ready       : command handshake, ready only in IDLE
//   cmd_opcode                : 000 ADD, 001 SUB, 011 TRANSPOSE, others illegal
//   cmd_addr_a/_b/_c          : operand A, operand B, result word addresses
//   ram_address/wren/wdata    : registered RAM port, owned by this block
//   ram_rdata                 : RAM read data, RD_LATENCY cycles after address
//   alu_op/alu_a/alu_b        : datapath select and registered operands
//   alu_result                : datapath result, ALU_LATENCY cycles after operands
//   busy/done/err             : status; done (and err for illegal ops) pulse once
//   op_count                  : completed legal operations, wraps at 16 bits
module matrix_op_sequencer
  import matrix_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int RD_LATENCY  = 2,
  parameter int ALU_LATENCY = 0
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_opcode,
  input  logic [ADDR_W-1:0] cmd_addr_a,
  input  logic [ADDR_W-1:0] cmd_addr_b,
  input  logic [ADDR_W-1:0] cmd_addr_c,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       op_count
);

  // A read state lasts RD_LATENCY+1 cycles: the address is presented on the
  // first cycle and the data is sampled on the edge ending the last one.
  localparam logic [WAIT_W-1:0] RD_WAIT  = WAIT_W'(RD_LATENCY);
  localparam logic [WAIT_W-1:0] ALU_WAIT = WAIT_W'(ALU_LATENCY);

  state_e            state_q,       state_d;
  logic [2:0]        opcode_q,      opcode_d;
  logic [ADDR_W-1:0] addr_b_q,      addr_b_d;
  logic [ADDR_W-1:0] addr_c_q,      addr_c_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic              ram_wren_q,    ram_wren_d;
  logic [DATA_W-1:0] ram_wdata_q,   ram_wdata_d;
  logic [DATA_W-1:0] alu_a_q,       alu_a_d;
  logic [DATA_W-1:0] alu_b_q,       alu_b_d;
  logic [1:0]        alu_op_q,      alu_op_d;
  logic [15:0]       op_count_q,    op_count_d;

  logic              cnt_load;
  logic [WAIT_W-1:0] cnt_val;
  logic              cnt_zero;

  matrix_wait_counter u_wait (
    .mclk     (mclk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    addr_b_d      = addr_b_q;
    addr_c_d      = addr_c_q;
    ram_address_d = ram_address_q;
    ram_wren_d    = 1'b0;
    ram_wdata_d   = ram_wdata_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_op_d      = alu_op_q;
    op_count_d    = op_count_q;
    cnt_load      = 1'b0;
    cnt_val       = '0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          opcode_d = cmd_opcode;
          addr_b_d = cmd_addr_b;
          addr_c_d = cmd_addr_c;
          if (op_is_legal(cmd_opcode)) begin
            // Address A goes out on the acceptance edge so the read starts
            // in the first RD_A cycle.
            alu_op_d      = op_to_alu_sel(cmd_opcode);
            ram_address_d = cmd_addr_a;
            cnt_load      = 1'b1;
            cnt_val       = RD_WAIT;
            state_d       = ST_RD_A;
          end else begin
            // Illegal opcodes never touch the RAM port.
            state_d = ST_DONE;
          end
        end
      end

      ST_RD_A: begin
        if (cnt_zero) begin
          alu_a_d  = ram_rdata;
          cnt_load = 1'b1;
          if (opcode_q == OP_TRANSPOSE) begin
            cnt_val = ALU_WAIT;
            state_d = ST_EXEC;
          end else begin
            ram_address_d = addr_b_q;
            cnt_val       = RD_WAIT;
            state_d       = ST_RD_B;
          end
        end
      end

      ST_RD_B: begin
        if (cnt_zero) begin
          alu_b_d  = ram_rdata;
          cnt_load = 1'b1;
          cnt_val  = ALU_WAIT;
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cnt_zero) begin
          ram_wdata_d   = alu_result;
          ram_address_d = addr_c_q;
          ram_wren_d    = 1'b1;
          state_d       = ST_WRITE;
        end
      end

      ST_WRITE: begin
        op_count_d = op_count_q + 16'd1;
        state_d    = ST_DONE;
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      opcode_q      <= OP_ADD;
      addr_b_q      <= '0;
      addr_c_q      <= '0;
      ram_address_q <= '0;
      ram_wren_q    <= 1'b0;
      ram_wdata_q   <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= ALU_SUM;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      addr_b_q      <= addr_b_d;
      addr_c_q      <= addr_c_d;
      ram_address_q <= ram_address_d;
      ram_wren_q    <= ram_wren_d;
      ram_wdata_q   <= ram_wdata_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_op_q      <= alu_op_d;
      op_count_q    <= op_count_d;
    end
  end

  assign cmd_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = (state_q == ST_DONE) && !op_is_legal(opcode_q);
  assign ram_address = ram_address_q;
  assign ram_wren    = ram_wren_q;
  assign ram_wdata   = ram_wdata_q;
  assign alu_op      = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign op_count    = op_count_q;

endmodule

// File: doc/matrix_op_sequencer.md
Name: matrix_op_sequencer

Overview:
Command-driven controller for the matrix coprocessor. It accepts one matrix instruction (opcode plus three RAM word addresses) per valid/ready handshake. It then reads operand A and, for binary ops, operand B from the 256-bit single-port RAM, and drives registered operands into the add/sub/transpose datapath. It writes the result word back to RAM and reports completion. It replaces ad-hoc fixed-address sequencing with a reusable, latency-parameterised FSM that owns the RAM port.

Parameters:
ADDR_W, 8, RAM word address width
DATA_W, 256, matrix word width (4x4 or 5x5 packed elements, opaque to this block)
RD_LATENCY, 2, mclk cycles from ram_address valid to ram_rdata valid (1..7)
ALU_LATENCY, 0, extra mclk cycles from operands stable to alu_result valid (0..7)

Ports:
mclk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_opcode  input  3  000 ADD, 001 SUB, 011 TRANSPOSE, others illegal
cmd_addr_a  input  ADDR_W  operand A word address
cmd_addr_b  input  ADDR_W  operand B word address (ignored for TRANSPOSE)
cmd_addr_c  input  ADDR_W  result word address
ram_address  output  ADDR_W  registered RAM address
ram_wren  output  1  registered RAM write enable
ram_wdata  output  DATA_W  write data = captured alu_result
ram_rdata  input  DATA_W  RAM read data
alu_op  output  2  00 sum, 01 sub, 11 transpose (datapath mux select)
alu_a  output  DATA_W  registered operand A
alu_b  output  DATA_W  registered operand B
alu_result  input  DATA_W  datapath result
busy  output  1  high in every state except IDLE
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse with done for an illegal opcode
op_count  output  16  completed legal ops; wraps FFFF->0000

Behaviour:
- Reset (rst=0 at a posedge): state=IDLE. cmd_ready=1 after reset; busy, done, err, ram_wren=0; ram_address, alu_a, alu_b, ram_wdata, op_count=0; alu_op=00. Reset has priority over all other events.
- cmd_ready = (state==IDLE). A command is accepted on a posedge with cmd_valid & cmd_ready; opcode and addresses are latched. Later changes on cmd_* are ignored until the next IDLE.
- States: IDLE, RD_A, RD_B, EXEC, WRITE, DONE. A wait counter of 3 bits is reused across states.
- Cycle 0 is the acceptance cycle.
- RD_A: ram_address=addr_a, ram_wren=0. It lasts RD_LATENCY+1 cycles. alu_a<=ram_rdata on its final edge.
- RD_B (ADD/SUB only): same as RD_A with addr_b into alu_b. TRANSPOSE skips RD_B, and alu_b holds its prior value.
- EXEC: lasts ALU_LATENCY+1 cycles. alu_op is driven from the latched opcode from acceptance onward. ram_wdata<=alu_result on the final edge.
- WRITE: exactly 1 cycle with ram_address=addr_c and ram_wren=1. The RAM samples the write on the edge that ends WRITE.
- DONE: 1 cycle with done=1 and busy=1. op_count increments on entry. The next state is IDLE.
- Latency at defaults, counted from cycle 0 to the done cycle: ADD/SUB 9 (RD_A 1-3, RD_B 4-6, EXEC 7, WRITE 8, DONE 9); TRANSPOSE 6. cmd_ready returns the cycle after DONE, so throughput is one command per 10 or 7 cycles.
- Illegal opcode: accepted normally, then IDLE->DONE at cycle 1 with done=1 and err=1. There is no RAM access, ram_wren stays 0, and op_count does not increment.
- Address aliasing: addr_c equal to addr_a or addr_b is legal. Operands are captured before WRITE, so the write uses the old values.
- Reset mid-operation: state returns to IDLE and outputs reset; no done is issued. If reset coincides with the edge ending WRITE, that RAM write still commits, because the RAM samples wren=1 on the same edge. This is documented, not prevented.
- cmd_valid held high continuously: back-to-back commands are accepted only in IDLE; none are lost or duplicated.

Decomposition:
- Package matrix_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_TRANSPOSE;
  - ALU select encodings;
  - FSM state encoding;
  - DATA_W/ADDR_W defaults.
- Sub-module matrix_wait_counter: loadable 3-bit down-counter with a zero flag, instantiated once and reused for the RD and EXEC waits. Everything else stays in a single FSM.

Test Plan:
- Reset, then ADD with A@1=all 0x01 bytes, B@2=all 0x02 bytes, C@3 -> done at cycle 9, RAM[3]=all 0x03, op_count=1, err=0.
- SUB with A@5=0x10 bytes, B@6=0x04 bytes, C@5 (aliased) -> RAM[5]=0x0C bytes, and RAM[5] is read as 0x10 before the write.
- TRANSPOSE A@1 with a known pattern, C@7 -> done at cycle 6, RAM[7]=transpose, and no RAM access to addr_b.
- Opcode 010 -> done+err at cycle 1, ram_wren never 1, op_count unchanged; cmd_ready back at cycle 2.
- rst=0 during RD_B -> IDLE next cycle, busy=0, no done, RAM[C] unchanged; the next ADD completes correctly.
- 3 back-to-back commands with cmd_valid held high, plus op_count preset via 65535 ops (or forced) -> each command accepted exactly once; op_count wraps to 0.
